// File: rtl/cp0_exception_unit.sv
// cp0_exception_unit: CP0 registers, exception prioritisation/commit and pipeline flush/redirect
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   HW_Int[5:0]                   level-sensitive hardware interrupt lines
//   MEM_Valid, MEM_ExceptType,    MEM-stage instruction, its exception flags, PC,
//   MEM_PC, MEM_IsDelaySlot,      delay-slot marker and effective data address
//   MEM_ALUOut
//   WB_CP0Wr, WB_Dst, WB_Sel,     MTC0 commit from WB
//   WB_OutB
//   ID_CP0Addr, ID_CP0Sel,        MFC0 read port serving ID (combinational, WB bypassed)
//   CP0_RdData
//   Int_Pending                   interrupt tag for the next instruction entering the pipe
//   Exc_Flush, Exc_Redirect,      pipeline flush and fetch restart
//   Exc_TargetPC
//   CP0_Status/Cause/EPC          live register copies
// MEM_ExceptType bit order, highest priority first:
//   [8] Interrupt  [7] WrongAddressinIF  [6] ReservedInstruction  [5] Overflow  [4] Syscall
//   [3] Break  [2] RdWrongAddressinMEM  [1] WrWrongAddressinMEM  [0] Eret
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  HW_Int,
    input  logic        MEM_Valid,
    input  logic [8:0]  MEM_ExceptType,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_IsDelaySlot,
    input  logic [31:0] MEM_ALUOut,
    input  logic        WB_CP0Wr,
    input  logic [4:0]  WB_Dst,
    input  logic [2:0]  WB_Sel,
    input  logic [31:0] WB_OutB,
    input  logic [4:0]  ID_CP0Addr,
    input  logic [2:0]  ID_CP0Sel,
    output logic [31:0] CP0_RdData,
    output logic        Int_Pending,
    output logic        Exc_Flush,
    output logic        Exc_Redirect,
    output logic [31:0] Exc_TargetPC,
    output logic [31:0] CP0_Status,
    output logic [31:0] CP0_Cause,
    output logic [31:0] CP0_EPC
);
    localparam logic [4:0]  R_BADVADDR   = 5'd8;
    localparam logic [4:0]  R_COUNT      = 5'd9;
    localparam logic [4:0]  R_COMPARE    = 5'd11;
    localparam logic [4:0]  R_STATUS     = 5'd12;
    localparam logic [4:0]  R_CAUSE      = 5'd13;
    localparam logic [4:0]  R_EPC        = 5'd14;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    logic [31:0] bad_vaddr, count, compare, status, cause, epc;
    logic        tick;
    logic        wr0, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [31:0] status_w, cause_w, epc_w, count_w, compare_w;
    logic [31:0] count_next, status_next, cause_next, epc_next, bad_vaddr_next;
    logic        ti_next;
    logic [8:0]  exc;
    logic [4:0]  exc_code;
    logic        exc_hit, is_eret, take, bad_if, bad_mem;

    assign wr0        = WB_CP0Wr && WB_Sel == 3'd0;
    assign wr_count   = wr0 && WB_Dst == R_COUNT;
    assign wr_compare = wr0 && WB_Dst == R_COMPARE;
    assign wr_status  = wr0 && WB_Dst == R_STATUS;
    assign wr_cause   = wr0 && WB_Dst == R_CAUSE;
    assign wr_epc     = wr0 && WB_Dst == R_EPC;

    // Post-MTC0 view of each register: feeds both the read bypass and the exception update,
    // so an older MTC0 lands first and the exception overrides only its own fields.
    assign status_w  = wr_status  ? (status & ~STATUS_WMASK) | (WB_OutB & STATUS_WMASK) : status;
    assign cause_w   = wr_cause   ? (cause & ~CAUSE_WMASK) | (WB_OutB & CAUSE_WMASK) : cause;
    assign epc_w     = wr_epc     ? WB_OutB : epc;
    assign count_w   = wr_count   ? WB_OutB : count;
    assign compare_w = wr_compare ? WB_OutB : compare;

    // A bubble can still carry the Interrupt tag; every other flag needs a real instruction.
    assign exc = MEM_ExceptType & {1'b1, {8{MEM_Valid}}};

    always_comb begin
        exc_code = 5'd0;
        bad_if   = 1'b0;
        bad_mem  = 1'b0;
        is_eret  = 1'b0;
        if (exc[8])      exc_code = 5'd0;
        else if (exc[7]) begin exc_code = 5'd4; bad_if = 1'b1; end
        else if (exc[6]) exc_code = 5'd10;
        else if (exc[5]) exc_code = 5'd12;
        else if (exc[4]) exc_code = 5'd8;
        else if (exc[3]) exc_code = 5'd9;
        else if (exc[2]) begin exc_code = 5'd4; bad_mem = 1'b1; end
        else if (exc[1]) begin exc_code = 5'd5; bad_mem = 1'b1; end
        else             is_eret = exc[0];
    end

    assign exc_hit      = |exc;
    assign take         = exc_hit & ~is_eret;
    assign Exc_Flush    = exc_hit;
    assign Exc_Redirect = exc_hit;
    assign Exc_TargetPC = is_eret ? epc_w : EXC_VECTOR;
    assign Int_Pending  = status[0] & ~status[1] & |(status[15:8] & cause[15:8]);

    always_comb begin
        count_next = wr_count ? WB_OutB : count + {31'd0, tick};
        // TI is sticky until software rewrites Compare; Compare==0 disables the timer.
        ti_next = ~wr_compare & (cause[30] | (count_next == compare && compare != 32'd0));
        cause_next        = cause_w;
        cause_next[30]    = ti_next;
        cause_next[15:10] = {HW_Int[5] | cause[30], HW_Int[4:0]};
        status_next    = status_w;
        epc_next       = epc_w;
        bad_vaddr_next = bad_vaddr;
        if (take) begin
            cause_next[6:2] = exc_code;
            status_next[1]  = 1'b1;
            // Nested exception: keep the restart point of the outer one.
            if (!status_w[1]) begin
                epc_next       = MEM_IsDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
                cause_next[31] = MEM_IsDelaySlot;
            end
            if (bad_if)       bad_vaddr_next = MEM_PC;
            else if (bad_mem) bad_vaddr_next = MEM_ALUOut;
        end
        if (is_eret) status_next[1] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bad_vaddr <= 32'd0;
            count     <= 32'd0;
            compare   <= 32'd0;
            status    <= RESET_STATUS;
            cause     <= 32'd0;
            epc       <= 32'd0;
            tick      <= 1'b0;
        end else begin
            bad_vaddr <= bad_vaddr_next;
            count     <= count_next;
            compare   <= compare_w;
            status    <= status_next;
            cause     <= cause_next;
            epc       <= epc_next;
            tick      <= ~tick;
        end
    end

    always_comb begin
        CP0_RdData = 32'd0;
        if (ID_CP0Sel == 3'd0)
            case (ID_CP0Addr)
                R_BADVADDR: CP0_RdData = bad_vaddr;
                R_COUNT:    CP0_RdData = count_w;
                R_COMPARE:  CP0_RdData = compare_w;
                R_STATUS:   CP0_RdData = status_w;
                R_CAUSE:    CP0_RdData = cause_w;
                R_EPC:      CP0_RdData = epc_w;
                default:    CP0_RdData = 32'd0;
            endcase
    end

    assign CP0_Status = status;
    assign CP0_Cause  = cause;
    assign CP0_EPC    = epc;
endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb_cp0_exception_unit: self-checking bench for cp0_exception_unit
module tb_cp0_exception_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  HW_Int = '0;
    logic        MEM_Valid = 1'b0;
    logic [8:0]  MEM_ExceptType = '0;
    logic [31:0] MEM_PC = '0;
    logic        MEM_IsDelaySlot = 1'b0;
    logic [31:0] MEM_ALUOut = '0;
    logic        WB_CP0Wr = 1'b0;
    logic [4:0]  WB_Dst = '0;
    logic [2:0]  WB_Sel = '0;
    logic [31:0] WB_OutB = '0;
    logic [4:0]  ID_CP0Addr = '0;
    logic [2:0]  ID_CP0Sel = '0;
    logic [31:0] CP0_RdData, Exc_TargetPC, CP0_Status, CP0_Cause, CP0_EPC;
    logic        Int_Pending, Exc_Flush, Exc_Redirect;

    localparam logic [4:0] R_BADV = 5'd8, R_COUNT = 5'd9, R_CMP = 5'd11;
    localparam logic [4:0] R_STATUS = 5'd12, R_CAUSE = 5'd13, R_EPC = 5'd14;
    localparam logic [8:0] T_INT = 9'h100, T_IFADEL = 9'h080, T_OV = 9'h020, T_SYS = 9'h010;
    localparam logic [8:0] T_BRK = 9'h008, T_ADEL = 9'h004, T_ADES = 9'h002, T_ERET = 9'h001;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    cp0_exception_unit dut (
        .clk(clk), .rst(rst), .HW_Int(HW_Int), .MEM_Valid(MEM_Valid),
        .MEM_ExceptType(MEM_ExceptType), .MEM_PC(MEM_PC), .MEM_IsDelaySlot(MEM_IsDelaySlot),
        .MEM_ALUOut(MEM_ALUOut), .WB_CP0Wr(WB_CP0Wr), .WB_Dst(WB_Dst), .WB_Sel(WB_Sel),
        .WB_OutB(WB_OutB), .ID_CP0Addr(ID_CP0Addr), .ID_CP0Sel(ID_CP0Sel),
        .CP0_RdData(CP0_RdData), .Int_Pending(Int_Pending), .Exc_Flush(Exc_Flush),
        .Exc_Redirect(Exc_Redirect), .Exc_TargetPC(Exc_TargetPC), .CP0_Status(CP0_Status),
        .CP0_Cause(CP0_Cause), .CP0_EPC(CP0_EPC)
    );

    always #10 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_reg(input string n, input logic [4:0] a, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.addr = a;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic mem(input logic v, input logic [8:0] t, input logic [31:0] pc,
                       input logic ds, input logic [31:0] alu);
        MEM_Valid = v;
        MEM_ExceptType = t;
        MEM_PC = pc;
        MEM_IsDelaySlot = ds;
        MEM_ALUOut = alu;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        WB_CP0Wr = 1'b1;
        WB_Dst = r;
        WB_OutB = d;
        @(posedge clk);
        #1;
        WB_CP0Wr = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (Int_Pending !== 1'b0 || Exc_Flush !== 1'b0 || Exc_Redirect !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got int=%b flush=%b redir=%b expected 0 0 0",
                     Int_Pending, Exc_Flush, Exc_Redirect);
        end
        rst = 1'b1;
        expect_reg("reset_status", R_STATUS, 32'h0040_0000);
        expect_reg("reset_cause", R_CAUSE, 32'h0);
        expect_reg("reset_epc", R_EPC, 32'h0);
        expect_reg("reset_count", R_COUNT, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        expect_reg("count_after_2clk", R_COUNT, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        expect_reg("count_after_4clk", R_COUNT, 32'd2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        mem(1'b1, T_OV, 32'h8000_0100, 1'b0, 32'h0);
        #1;
        checks++;
        if (Exc_Flush !== 1'b1 || Exc_Redirect !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flush: got flush=%b redir=%b expected 1 1", Exc_Flush, Exc_Redirect);
        end
        checks++;
        if (Exc_TargetPC !== VEC) begin
            failures++;
            $display("FAIL ovf_target: got %h expected %h", Exc_TargetPC, VEC);
        end
        @(posedge clk);
        #1;
        mem(1'b0, 9'h0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (CP0_EPC !== 32'h8000_0100) begin
            failures++;
            $display("FAIL ovf_epc_live: got %h expected %h", CP0_EPC, 32'h8000_0100);
        end
        expect_reg("ovf_epc", R_EPC, 32'h8000_0100);
        expect_reg("ovf_cause", R_CAUSE, 32'h0000_0030);
        expect_reg("ovf_status", R_STATUS, 32'h0040_0002);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
    endtask

    task automatic test_adel();
        exp_t e;
        mtc0(R_STATUS, 32'h0);
        mem(1'b1, T_ADEL, 32'h8000_0204, 1'b1, 32'h0000_0003);
        @(posedge clk);
        #1;
        mem(1'b0, 9'h0, 32'h0, 1'b0, 32'h0);
        expect_reg("adel_epc", R_EPC, 32'h8000_0200);
        expect_reg("adel_badvaddr", R_BADV, 32'h0000_0003);
        expect_reg("adel_cause", R_CAUSE, 32'h8000_0010);
        expect_reg("adel_status", R_STATUS, 32'h0040_0002);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
    endtask

    task automatic test_syscall_eret();
        exp_t e;
        mem(1'b1, T_SYS, 32'h8000_0300, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        mem(1'b0, 9'h0, 32'h0, 1'b0, 32'h0);
        expect_reg("sys_cause", R_CAUSE, 32'h8000_0020);
        expect_reg("sys_epc_kept", R_EPC, 32'h8000_0200);
        expect_reg("sys_status", R_STATUS, 32'h0040_0002);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        mem(1'b1, T_ERET, 32'h8000_0700, 1'b0, 32'h0);
        #1;
        checks++;
        if (Exc_Redirect !== 1'b1 || Exc_TargetPC !== 32'h8000_0200) begin
            failures++;
            $display("FAIL eret_redirect: got redir=%b pc=%h expected 1 %h",
                     Exc_Redirect, Exc_TargetPC, 32'h8000_0200);
        end
        @(posedge clk);
        #1;
        mem(1'b0, 9'h0, 32'h0, 1'b0, 32'h0);
        expect_reg("eret_status", R_STATUS, 32'h0040_0000);
        expect_reg("eret_cause", R_CAUSE, 32'h8000_0020);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        mem(1'b0, T_OV | T_SYS | T_ERET, 32'h8000_0400, 1'b0, 32'h0);
        #1;
        checks++;
        if (Exc_Flush !== 1'b0 || Exc_Redirect !== 1'b0) begin
            failures++;
            $display("FAIL bubble_no_flush: got flush=%b redir=%b expected 0 0", Exc_Flush, Exc_Redirect);
        end
        mem(1'b1, T_OV | T_SYS | T_BRK | T_ERET, 32'h8000_0380, 1'b0, 32'h0);
        #1;
        checks++;
        if (Exc_TargetPC !== VEC) begin
            failures++;
            $display("FAIL prio_ovf_target: got %h expected %h", Exc_TargetPC, VEC);
        end
        @(posedge clk);
        #1;
        mem(1'b0, 9'h0, 32'h0, 1'b0, 32'h0);
        expect_reg("prio_ovf_cause", R_CAUSE, 32'h0000_0030);
        expect_reg("prio_ovf_epc", R_EPC, 32'h8000_0380);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        mtc0(R_STATUS, 32'h0);
        mem(1'b1, T_IFADEL | T_ADES, 32'h8000_0400, 1'b0, 32'h0000_0011);
        @(posedge clk);
        #1;
        mem(1'b0, 9'h0, 32'h0, 1'b0, 32'h0);
        expect_reg("prio_if_badvaddr", R_BADV, 32'h8000_0400);
        expect_reg("prio_if_cause", R_CAUSE, 32'h0000_0010);
        expect_reg("prio_if_epc", R_EPC, 32'h8000_0400);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        mtc0(R_STATUS, 32'h0);
        mem(1'b0, T_INT, 32'h8000_0500, 1'b1, 32'h0);
        #1;
        checks++;
        if (Exc_Flush !== 1'b1) begin
            failures++;
            $display("FAIL bubble_int_flush: got %b expected 1", Exc_Flush);
        end
        @(posedge clk);
        #1;
        mem(1'b0, 9'h0, 32'h0, 1'b0, 32'h0);
        expect_reg("int_cause", R_CAUSE, 32'h8000_0000);
        expect_reg("int_epc", R_EPC, 32'h8000_04FC);
        expect_reg("int_status", R_STATUS, 32'h0040_0002);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        mtc0(R_STATUS, 32'h0);
    endtask

    task automatic test_hw_int();
        exp_t e;
        mtc0(R_STATUS, 32'h0000_0401);
        HW_Int = 6'b000001;
        #1;
        checks++;
        if (Int_Pending !== 1'b0) begin
            failures++;
            $display("FAIL hw_int_latency: got %b expected 0", Int_Pending);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Int_Pending !== 1'b1) begin
            failures++;
            $display("FAIL hw_int_pending: got %b expected 1", Int_Pending);
        end
        expect_reg("hw_int_cause", R_CAUSE, 32'h8000_0400);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        mtc0(R_STATUS, 32'h0000_0403);
        checks++;
        if (Int_Pending !== 1'b0) begin
            failures++;
            $display("FAIL exl_masks_int: got %b expected 0", Int_Pending);
        end
        HW_Int = 6'b0;
        mtc0(R_STATUS, 32'h0);
    endtask

    task automatic test_timer();
        exp_t e;
        logic seen;
        mtc0(R_COUNT, 32'h0);
        mtc0(R_CMP, 32'd10);
        mtc0(R_STATUS, 32'h0000_8001);
        ID_CP0Addr = R_CAUSE;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk);
            #1;
            seen = CP0_RdData[30];
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL timer_ti_rise: got no TI within 40 cycles expected TI=1");
        end
        checks++;
        if (Int_Pending !== 1'b0) begin
            failures++;
            $display("FAIL timer_pending_latency: got %b expected 0", Int_Pending);
        end
        expect_reg("timer_count", R_COUNT, 32'd10);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (Int_Pending !== 1'b1) begin
            failures++;
            $display("FAIL timer_pending: got %b expected 1", Int_Pending);
        end
        expect_reg("timer_cause", R_CAUSE, 32'hC000_8000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        mtc0(R_CMP, 32'h0);
        @(posedge clk);
        #1;
        checks++;
        if (Int_Pending !== 1'b0) begin
            failures++;
            $display("FAIL timer_clear_pending: got %b expected 0", Int_Pending);
        end
        expect_reg("timer_clear_cause", R_CAUSE, 32'h8000_0000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        ID_CP0Addr = R_EPC;
        WB_CP0Wr = 1'b1;
        WB_Dst = R_EPC;
        WB_OutB = 32'h1234_5678;
        mem(1'b1, T_BRK, 32'h8000_0600, 1'b0, 32'h0);
        #1;
        checks++;
        if (CP0_RdData !== 32'h1234_5678) begin
            failures++;
            $display("FAIL mfc0_bypass: got %h expected %h", CP0_RdData, 32'h1234_5678);
        end
        @(posedge clk);
        #1;
        WB_CP0Wr = 1'b0;
        mem(1'b0, 9'h0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (CP0_Status !== 32'h0040_8003 || CP0_Cause !== 32'h0000_0024) begin
            failures++;
            $display("FAIL brk_live: got status=%h cause=%h expected 00408003 00000024",
                     CP0_Status, CP0_Cause);
        end
        expect_reg("brk_epc_over_mtc0", R_EPC, 32'h8000_0600);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        mtc0(R_BADV, 32'hDEAD_BEEF);
        mtc0(R_CAUSE, 32'hFFFF_FFFF);
        mtc0(R_COUNT, 32'hFFFF_FFFF);
        expect_reg("badvaddr_readonly", R_BADV, 32'h8000_0400);
        expect_reg("cause_wmask", R_CAUSE, 32'h0000_0324);
        expect_reg("count_write", R_COUNT, 32'hFFFF_FFFF);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        expect_reg("count_wrap", R_COUNT, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        ID_CP0Sel = 3'd1;
        ID_CP0Addr = R_STATUS;
        #1;
        checks++;
        if (CP0_RdData !== 32'h0) begin
            failures++;
            $display("FAIL read_sel1: got %h expected 0", CP0_RdData);
        end
        ID_CP0Sel = 3'd0;
        ID_CP0Addr = 5'd0;
        #1;
        checks++;
        if (CP0_RdData !== 32'h0) begin
            failures++;
            $display("FAIL read_unimpl: got %h expected 0", CP0_RdData);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        mem(1'b1, T_OV, 32'h8000_0800, 1'b0, 32'h0);
        #3;
        rst = 1'b0;
        #1;
        expect_reg("rmid_status", R_STATUS, 32'h0040_0000);
        expect_reg("rmid_cause", R_CAUSE, 32'h0);
        expect_reg("rmid_epc", R_EPC, 32'h0);
        expect_reg("rmid_badvaddr", R_BADV, 32'h0);
        expect_reg("rmid_count", R_COUNT, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ID_CP0Addr = e.addr;
            #1;
            checks++;
            if (CP0_RdData !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, CP0_RdData, e.val);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem(1'b0, 9'h0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_adel();
        test_syscall_eret();
        test_priority();
        test_hw_int();
        test_timer();
        test_bypass();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
